// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V datapath types. Only the ALU operation encoding
// is needed by the ALU arbiter and its interface.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ops_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the per-requester request/response channels and the
// shared-ALU connection of alu_arbiter.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. valid, once raised by the producer, is
// held with stable payload until that edge; ready may be computed
// combinationally from valid and is only meaningful while valid is high.
// Requesters may withdraw req_valid before being granted; the arbiter never
// withdraws resp_valid before resp_ready.
//
// Modports: slave is the arbiter; master is its environment (requesters,
// response sinks and the combinational ALU).
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import riscv_pkg::*;

  // request channel, one lane per requester
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  alu_ops_t                 req_op [NUM_REQ];

  // response channel: valid/ready per requester, payload shared
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [31:0]              resp_result;
  logic                     resp_zero;

  // shared combinational ALU
  logic [31:0]              alu_a;
  logic [31:0]              alu_b;
  alu_ops_t                 alu_ctrl;
  logic [31:0]              alu_result;
  logic                     alu_zero;

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready, alu_result, alu_zero,
    output req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready, alu_result, alu_zero,
    input  req_ready, resp_valid, resp_result, resp_zero, alu_a, alu_b, alu_ctrl
  );

endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters with
// round-robin arbitration and a single operation in flight.
//
// Flow: IDLE grants one requester (req_ready combinational, operands latched
// on the edge) -> EXEC drives the ALU from the latched registers and samples
// its result -> RESP holds the response until the granted requester takes it.
// A request accepted in cycle T produces resp_valid in cycle T+2.
//
// Optional feature: define ALU_ARB_PERF_EN to add perf_grant_cnt (per
// requester accepted-request count, saturating) and perf_stall_cnt (cycles
// with a pending request but no grant, wrapping).
//
// dbg_state / dbg_rr expose the FSM state (0=IDLE, 1=EXEC, 2=RESP) and the
// round-robin pointer.
module alu_arbiter
  import riscv_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  alu_arbiter_if.slave              bus,
  output logic [1:0]                dbg_state,
  output logic [IDW-1:0]            dbg_rr
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][15:0]  perf_grant_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [IDW-1:0] rr_q;        // first requester considered in the next search
  logic [IDW-1:0] gnt_q;       // requester owning the in-flight operation
  logic [31:0]    a_q;
  logic [31:0]    b_q;
  alu_ops_t       op_q;
  logic [31:0]    result_q;
  logic           zero_q;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic           grant_fire;
  logic           resp_fire;

  // (base + off) mod NUM_REQ; off never exceeds NUM_REQ so one subtract suffices
  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                              input int unsigned    off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
    return IDW'(s);
  endfunction

  // round-robin search: first valid requester at or after rr_q, wrapping
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_valid && bus.req_valid[wrap_add(rr_q, 32'(i))]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_add(rr_q, 32'(i));
      end
    end
  end

  // handshake events that move the FSM and the datapath
  always_comb begin
    grant_fire = (state_q == S_IDLE) && pick_valid;
    resp_fire  = (state_q == S_RESP) && bus.resp_ready[gnt_q];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; EXEC always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_fire) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (resp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath registers: operand capture on grant, result capture in EXEC,
  // pointer advance on the response handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      gnt_q    <= '0;
      rr_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      if (grant_fire) begin
        a_q   <= bus.req_a[pick_idx];
        b_q   <= bus.req_b[pick_idx];
        op_q  <= bus.req_op[pick_idx];
        gnt_q <= pick_idx;
      end
      if (state_q == S_EXEC) begin
        result_q <= bus.alu_result;
        zero_q   <= bus.alu_zero;
      end
      if (resp_fire) begin
        rr_q <= wrap_add(gnt_q, 32'd1);
      end
    end
  end

  // FSM outputs: one-hot ready/valid lanes and registered ALU/response drives
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i]  = grant_fire && (pick_idx == IDW'(i));
      bus.resp_valid[i] = (state_q == S_RESP) && (gnt_q == IDW'(i));
    end
    bus.resp_result = result_q;
    bus.resp_zero   = zero_q;
    // ALU inputs come straight from the operand registers, so they only
    // change on a grant and stay quiet while idle
    bus.alu_a       = a_q;
    bus.alu_b       = b_q;
    bus.alu_ctrl    = op_q;
    dbg_state       = state_q;
    dbg_rr          = rr_q;
  end

`ifdef ALU_ARB_PERF_EN
  // performance counters: grants per requester (saturating) and stall cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i] && (perf_grant_cnt[i] != 16'hFFFF)) begin
          perf_grant_cnt[i] <= perf_grant_cnt[i] + 16'd1;
        end
      end
      if ((|bus.req_valid) && !(|bus.req_ready)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with NUM_REQ=2. Plays the
// requesters and the combinational ALU; expected responses are queued when a
// request is granted and compared when the response is presented.
module tb_alu_arbiter;
  import riscv_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int W       = 1 + NUM_REQ + 32;  // {zero, resp_valid lanes, result}

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  logic [0:0] dbg_rr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  alu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] perf_grant_cnt;
  logic [31:0]              perf_stall_cnt;
`endif

  alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_rr    (dbg_rr)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // behavioural ALU attached to the arbiter's ALU port
  always_comb begin
    case (bus.alu_ctrl)
      ALU_ADD:  bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB:  bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      ALU_SLL:  bus.alu_result = bus.alu_a << bus.alu_b[4:0];
      ALU_SRL:  bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
      ALU_SRA:  bus.alu_result = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
      ALU_SLT:  bus.alu_result = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      ALU_SLTU: bus.alu_result = {31'd0, bus.alu_a < bus.alu_b};
      default:  bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

`ifdef ALU_ARB_PERF_EN
  // reference counts for the perf counters, sampled mid-cycle
  int exp_grant [NUM_REQ];
  int exp_stall;
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) exp_grant[i] <= 0;
      exp_stall <= 0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i]) exp_grant[i] <= exp_grant[i] + 1;
      end
      if ((|bus.req_valid) && (bus.req_ready == '0)) exp_stall <= exp_stall + 1;
    end
  end
`endif

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [NUM_REQ-1:0] lanes, input logic [31:0] res,
                          input logic zero);
    exp_q.push_back({zero, lanes, res});
  endtask

  task automatic sb_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed response 0x%0h expected none queued", tag,
             {bus.resp_zero, bus.resp_valid, bus.resp_result});
    end else begin
      e = exp_q.pop_front();
      check(tag, 64'({bus.resp_zero, bus.resp_valid, bus.resp_result}), 64'(e));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for a grant, queue its expected response, wait for the response,
  // compare it and complete the handshake (resp_ready assumed high)
  task automatic run_grant(input string tag, input logic [NUM_REQ-1:0] exp_gnt,
                           input logic [31:0] exp_res, input logic exp_zero,
                           output int waited);
    int lat;
    waited = 0;
    while ((bus.req_ready == '0) && (waited < 10)) begin
      tick();
      waited++;
    end
    check({tag, " grant"}, 64'(bus.req_ready), 64'(exp_gnt));
    push_exp(exp_gnt, exp_res, exp_zero);
    tick();
    lat = 1;
    while ((bus.resp_valid == '0) && (lat < 10)) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd2);
    sb_check({tag, " resp"});
    tick();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic perf_check(input string tag);
    for (int i = 0; i < NUM_REQ; i++) begin
      check($sformatf("%s grant_cnt[%0d]", tag, i), 64'(perf_grant_cnt[i]), 64'(exp_grant[i]));
    end
    check({tag, " stall_cnt"}, 64'(perf_stall_cnt), 64'(exp_stall));
  endtask
`endif

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    rst_n          = 1'b0;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op[0]  = ALU_ADD;
    bus.req_op[1]  = ALU_ADD;
    bus.resp_ready = '0;
    tick();
    tick();

    // reset state
    check("rst req_ready",   64'(bus.req_ready),   64'd0);
    check("rst resp_valid",  64'(bus.resp_valid),  64'd0);
    check("rst resp_result", 64'(bus.resp_result), 64'd0);
    check("rst resp_zero",   64'(bus.resp_zero),   64'd0);
    check("rst alu_a",       64'(bus.alu_a),       64'd0);
    check("rst alu_b",       64'(bus.alu_b),       64'd0);
    check("rst alu_ctrl",    64'(bus.alu_ctrl),    64'(ALU_ADD));
    check("rst state",       64'(dbg_state),       64'(ST_IDLE));
    check("rst rr",          64'(dbg_rr),          64'd0);
    rst_n          = 1'b1;
    bus.resp_ready = 2'b11;
    tick();

    // single ADD from requester 0, stepped cycle by cycle
    bus.req_a[0]  = 32'd5;
    bus.req_b[0]  = 32'd7;
    bus.req_op[0] = ALU_ADD;
    bus.req_valid = 2'b01;
    #1;
    check("t1 req_ready T", 64'(bus.req_ready), 64'b01);
    push_exp(2'b01, 32'd12, 1'b0);
    tick();
    bus.req_valid = 2'b00;
    bus.req_a[0]  = 32'hDEAD_BEEF;  // changes after acceptance must not matter
    #1;
    check("t1 state EXEC",      64'(dbg_state),      64'(ST_EXEC));
    check("t1 alu_a",           64'(bus.alu_a),      64'd5);
    check("t1 alu_b",           64'(bus.alu_b),      64'd7);
    check("t1 alu_ctrl",        64'(bus.alu_ctrl),   64'(ALU_ADD));
    check("t1 resp_valid T+1",  64'(bus.resp_valid), 64'd0);
    check("t1 req_ready T+1",   64'(bus.req_ready),  64'd0);
    tick();
    check("t1 resp_valid T+2",  64'(bus.resp_valid), 64'b01);
    sb_check("t1 resp");
    tick();
    check("t1 state IDLE T+3",  64'(dbg_state),      64'(ST_IDLE));
    check("t1 resp_valid T+3",  64'(bus.resp_valid), 64'd0);
    check("t1 rr",              64'(dbg_rr),         64'd1);
    check("t1 alu_a held",      64'(bus.alu_a),      64'd5);

    // SUB to zero from requester 1
    bus.req_a[1]  = 32'h10;
    bus.req_b[1]  = 32'h10;
    bus.req_op[1] = ALU_SUB;
    bus.req_valid = 2'b10;
    #1;
    run_grant("t2 sub", 2'b10, 32'd0, 1'b1, w);
    bus.req_valid = 2'b00;
    check("t2 rr wrap", 64'(dbg_rr), 64'd0);

    // round robin with both requesters continuously valid
    bus.req_a[0]  = 32'hF0F0;
    bus.req_b[0]  = 32'h0FF0;
    bus.req_op[0] = ALU_XOR;
    bus.req_a[1]  = 32'd1;
    bus.req_b[1]  = 32'd2;
    bus.req_op[1] = ALU_OR;
    bus.req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) run_grant($sformatf("t3 rr%0d", k), 2'b01, 32'hFF00, 1'b0, w);
      else            run_grant($sformatf("t3 rr%0d", k), 2'b10, 32'd3,    1'b0, w);
      if (k > 0) check($sformatf("t3 spacing%0d", k), 64'(w), 64'd0);
    end
    bus.req_valid = 2'b00;
`ifdef ALU_ARB_PERF_EN
    perf_check("t3 perf");
`endif

    // response backpressure on requester 0 while requester 1 waits
    bus.resp_ready = 2'b00;
    bus.req_a[0]   = 32'd1;
    bus.req_b[0]   = 32'd2;
    bus.req_op[0]  = ALU_ADD;
    bus.req_valid  = 2'b01;
    #1;
    check("t4 grant0", 64'(bus.req_ready), 64'b01);
    push_exp(2'b01, 32'd3, 1'b0);
    tick();
    bus.req_a[1]  = 32'd9;
    bus.req_b[1]  = 32'd4;
    bus.req_op[1] = ALU_SUB;
    bus.req_valid = 2'b11;
    tick();
    check("t4 resp_valid", 64'(bus.resp_valid), 64'b01);
    bus.resp_ready = 2'b10;  // ready from the other requester must be ignored
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("t4 hold result c%0d", c), 64'(bus.resp_result), 64'd3);
      check($sformatf("t4 hold valid c%0d", c),  64'(bus.resp_valid),  64'b01);
      check($sformatf("t4 no grant c%0d", c),    64'(bus.req_ready),   64'd0);
    end
    bus.resp_ready = 2'b11;
    #1;
    sb_check("t4 resp0");
    tick();
    check("t4 state IDLE",   64'(dbg_state),     64'(ST_IDLE));
    check("t4 grant1 after", 64'(bus.req_ready), 64'b10);
    run_grant("t4 req1", 2'b10, 32'd5, 1'b0, w);
    bus.req_valid = 2'b00;

    // reset in the middle of an operation
    bus.req_a[0]  = 32'd10;
    bus.req_b[0]  = 32'd20;
    bus.req_op[0] = ALU_ADD;
    bus.req_valid = 2'b01;
    #1;
    run_grant("t5 pre", 2'b01, 32'd30, 1'b0, w);
    check("t5 rr before", 64'(dbg_rr), 64'd1);
    bus.req_a[0] = 32'd1;
    bus.req_b[0] = 32'd1;
    #1;
    check("t5 wrap grant", 64'(bus.req_ready), 64'b01);
    tick();
    bus.req_valid = 2'b00;
    check("t5 in EXEC", 64'(dbg_state), 64'(ST_EXEC));
    rst_n = 1'b0;
    tick();
    check("t5 resp_valid",  64'(bus.resp_valid),  64'd0);
    check("t5 resp_result", 64'(bus.resp_result), 64'd0);
    check("t5 state",       64'(dbg_state),       64'(ST_IDLE));
    check("t5 rr",          64'(dbg_rr),          64'd0);
    check("t5 alu_a",       64'(bus.alu_a),       64'd0);
    rst_n = 1'b1;
    tick();
    check("t5 no stale resp", 64'(bus.resp_valid), 64'd0);
    bus.req_a[0]  = 32'hFF;
    bus.req_b[0]  = 32'h0F;
    bus.req_op[0] = ALU_AND;
    bus.req_a[1]  = 32'h100;
    bus.req_b[1]  = 32'h001;
    bus.req_op[1] = ALU_OR;
    bus.req_valid = 2'b11;
    #1;
    run_grant("t5 post0", 2'b01, 32'h0F,  1'b0, w);
    run_grant("t5 post1", 2'b10, 32'h101, 1'b0, w);
    bus.req_valid = 2'b00;
`ifdef ALU_ARB_PERF_EN
    perf_check("t5 perf");
`endif

    check("sb drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
